// File: rtl/spi_mem_arbiter.sv
// Arbitrates one single-port memory between a buffered SPI request and a core port.
// Optional macro SPI_MEM_ARBITER_FAIR_EN switches contention from SPI-priority to alternating.
module spi_mem_arbiter #(
  parameter int DATA_BIT_WIDTH    = 32,
  parameter int ADDRESS_BIT_WIDTH = 16,
  parameter int CODE_BIT_WIDTH    = 4,
  parameter int MEM_CODE          = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_write_new,
  input  logic                         spi_read_sync,
  input  logic [CODE_BIT_WIDTH-1:0]    spi_code,
  input  logic [ADDRESS_BIT_WIDTH-1:0] spi_address,
  input  logic [DATA_BIT_WIDTH-1:0]    spi_write_data,
  output logic [DATA_BIT_WIDTH-1:0]    spi_read_data,
  output logic                         spi_overflow,
  input  logic                         core_req,
  input  logic                         core_we,
  input  logic [ADDRESS_BIT_WIDTH-1:0] core_addr,
  input  logic [DATA_BIT_WIDTH-1:0]    core_wdata,
  output logic                         core_gnt,
  output logic                         core_rvalid,
  output logic [DATA_BIT_WIDTH-1:0]    core_rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDRESS_BIT_WIDTH-1:0] mem_addr,
  output logic [DATA_BIT_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_BIT_WIDTH-1:0]    mem_rdata
);

  localparam logic [CODE_BIT_WIDTH-1:0] MEM_CODE_C = CODE_BIT_WIDTH'(MEM_CODE);

  typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

  state_t                         state, state_next;
  logic                           pending, pend_we;
  logic [ADDRESS_BIT_WIDTH-1:0]   pend_addr;
  logic [DATA_BIT_WIDTH-1:0]      pend_wdata;
  logic                           rd_spi;
  logic                           spi_hit, slot_free, core_want;
  logic                           pick_spi, pick_core;
`ifdef SPI_MEM_ARBITER_FAIR_EN
  logic                           last_spi;
`endif

  assign spi_hit   = (spi_write_new || spi_read_sync) && (spi_code == MEM_CODE_C);
  assign core_want = core_req && !core_gnt;
  // The pending slot frees at the same edge its request is issued.
  assign slot_free = !pending || pick_spi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pick_spi   = 1'b0;
    pick_core  = 1'b0;
    case (state)
      IDLE: begin
        if (pending && core_want) begin
`ifdef SPI_MEM_ARBITER_FAIR_EN
          if (last_spi) begin
            pick_core = 1'b1;
          end else begin
            pick_spi = 1'b1;
          end
`else
          pick_spi = 1'b1;
`endif
        end else if (pending) begin
          pick_spi = 1'b1;
        end else if (core_want) begin
          pick_core = 1'b1;
        end
        if ((pick_spi && !pend_we) || (pick_core && !core_we)) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= 1'b0;
      pend_we      <= 1'b0;
      pend_addr    <= '0;
      pend_wdata   <= '0;
      spi_overflow <= 1'b0;
    end else begin
      if (spi_hit && slot_free) begin
        pending    <= 1'b1;
        pend_we    <= spi_write_new;
        pend_addr  <= spi_address;
        pend_wdata <= spi_write_data;
      end else if (pick_spi) begin
        pending <= 1'b0;
      end
      if (spi_hit && (!slot_free || (spi_write_new && spi_read_sync))) begin
        spi_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_gnt  <= 1'b0;
      rd_spi    <= 1'b0;
    end else begin
      mem_en   <= pick_spi || pick_core;
      core_gnt <= pick_core;
      if (pick_spi) begin
        mem_we    <= pend_we;
        mem_addr  <= pend_addr;
        mem_wdata <= pend_wdata;
        rd_spi    <= 1'b1;
      end else if (pick_core) begin
        mem_we    <= core_we;
        mem_addr  <= core_addr;
        mem_wdata <= core_wdata;
        rd_spi    <= 1'b0;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

  // Read results are steered by who issued the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_read_data <= '0;
      core_rdata    <= '0;
      core_rvalid   <= 1'b0;
    end else begin
      core_rvalid <= 1'b0;
      if (state == RD_WAIT) begin
        if (rd_spi) begin
          spi_read_data <= mem_rdata;
        end else begin
          core_rdata  <= mem_rdata;
          core_rvalid <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_MEM_ARBITER_FAIR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_spi <= 1'b0;
    end else if (state == IDLE && pending && core_want) begin
      last_spi <= pick_spi;
    end
  end
`endif

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed self-checking bench for spi_mem_arbiter with a small behavioural memory.
module tb_spi_mem_arbiter;

`ifdef SPI_MEM_ARBITER_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_write_new, spi_read_sync;
  logic [3:0]  spi_code;
  logic [15:0] spi_address;
  logic [31:0] spi_write_data, spi_read_data;
  logic        spi_overflow;
  logic        core_req, core_we, core_gnt, core_rvalid;
  logic [15:0] core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0]  mem_words [0:255];
  logic [255:0] written;

  spi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .spi_write_new(spi_write_new), .spi_read_sync(spi_read_sync),
    .spi_code(spi_code), .spi_address(spi_address),
    .spi_write_data(spi_write_data), .spi_read_data(spi_read_data),
    .spi_overflow(spi_overflow),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten words read back as 0xA50000 followed by the low address byte.
  always @(posedge clk) begin
    if (rst) begin
      written <= '0;
    end else if (mem_en && mem_we) begin
      mem_words[mem_addr[7:0]] <= mem_wdata;
      written[mem_addr[7:0]]   <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = written[mem_addr[7:0]] ? mem_words[mem_addr[7:0]] : {24'hA50000, mem_addr[7:0]};
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] code,
                               input logic [15:0] addr, input logic [31:0] data);
    spi_write_new  = wr;
    spi_read_sync  = rd;
    spi_code       = code;
    spi_address    = addr;
    spi_write_data = data;
  endtask

  task automatic run_contention(input int k, input logic [15:0] s_addr, input logic [31:0] s_data,
                                input logic [15:0] c_addr, input logic [31:0] c_exp);
    logic spi_first;
    spi_first = !FAIR || (k % 2 == 0);
    applyStimulus(1'b1, 1'b0, 4'd1, s_addr, s_data);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 32'h0);
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = c_addr;
    tick();
    if (spi_first) begin
      checkOutput("cont_spi_en",   {63'd0, mem_en}, 64'd1);
      checkOutput("cont_spi_we",   {63'd0, mem_we}, 64'd1);
      checkOutput("cont_spi_addr", {48'd0, mem_addr}, {48'd0, s_addr});
      checkOutput("cont_spi_gnt",  {63'd0, core_gnt}, 64'd0);
      tick();
      checkOutput("cont_core_gnt",  {63'd0, core_gnt}, 64'd1);
      checkOutput("cont_core_we",   {63'd0, mem_we}, 64'd0);
      checkOutput("cont_core_addr", {48'd0, mem_addr}, {48'd0, c_addr});
      core_req = 1'b0;
      tick();
      checkOutput("cont_rvalid", {63'd0, core_rvalid}, 64'd1);
      checkOutput("cont_rdata",  {32'd0, core_rdata}, {32'd0, c_exp});
      tick();
    end else begin
      checkOutput("cont_core_gnt",  {63'd0, core_gnt}, 64'd1);
      checkOutput("cont_core_we",   {63'd0, mem_we}, 64'd0);
      checkOutput("cont_core_addr", {48'd0, mem_addr}, {48'd0, c_addr});
      core_req = 1'b0;
      tick();
      checkOutput("cont_rvalid",  {63'd0, core_rvalid}, 64'd1);
      checkOutput("cont_rdata",   {32'd0, core_rdata}, {32'd0, c_exp});
      checkOutput("cont_wait_en", {63'd0, mem_en}, 64'd0);
      tick();
      checkOutput("cont_spi_en",   {63'd0, mem_en}, 64'd1);
      checkOutput("cont_spi_we",   {63'd0, mem_we}, 64'd1);
      checkOutput("cont_spi_addr", {48'd0, mem_addr}, {48'd0, s_addr});
      tick();
    end
    checkOutput("cont_rvalid_drop", {63'd0, core_rvalid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 32'h0);
    core_req = 1'b0; core_we = 1'b0; core_addr = 16'h0; core_wdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_spi_rdata",  {32'd0, spi_read_data}, 64'd0);
    checkOutput("rst_overflow",   {63'd0, spi_overflow}, 64'd0);
    checkOutput("rst_mem_en",     {63'd0, mem_en}, 64'd0);
    checkOutput("rst_core_gnt",   {63'd0, core_gnt}, 64'd0);
    checkOutput("rst_core_rvalid",{63'd0, core_rvalid}, 64'd0);
    checkOutput("rst_core_rdata", {32'd0, core_rdata}, 64'd0);

    // SPI write passes straight to memory one edge after capture
    applyStimulus(1'b1, 1'b0, 4'd1, 16'h0010, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 32'h0);
    checkOutput("wr_capture_en", {63'd0, mem_en}, 64'd0);
    tick();
    checkOutput("wr_en",    {63'd0, mem_en}, 64'd1);
    checkOutput("wr_we",    {63'd0, mem_we}, 64'd1);
    checkOutput("wr_addr",  {48'd0, mem_addr}, 64'h0010);
    checkOutput("wr_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    checkOutput("wr_gnt",   {63'd0, core_gnt}, 64'd0);
    tick();
    checkOutput("wr_done_en", {63'd0, mem_en}, 64'd0);

    // SPI read returns on the third edge after the pulse
    applyStimulus(1'b0, 1'b1, 4'd1, 16'h0010, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 32'h0);
    tick();
    checkOutput("rd_en",        {63'd0, mem_en}, 64'd1);
    checkOutput("rd_we",        {63'd0, mem_we}, 64'd0);
    checkOutput("rd_not_yet",   {32'd0, spi_read_data}, 64'd0);
    tick();
    checkOutput("rd_data",      {32'd0, spi_read_data}, 64'hDEADBEEF);
    tick();
    checkOutput("rd_data_hold", {32'd0, spi_read_data}, 64'hDEADBEEF);

    // Foreign code is ignored
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0030, 32'h12345678);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 32'h0);
    tick();
    checkOutput("code0_en1", {63'd0, mem_en}, 64'd0);
    tick();
    checkOutput("code0_en2", {63'd0, mem_en}, 64'd0);
    checkOutput("code0_ovf", {63'd0, spi_overflow}, 64'd0);

    run_contention(0, 16'h0040, 32'hCAFEF00D, 16'h0020, 32'hA5000020);
    run_contention(1, 16'h0041, 32'hCAFEF00E, 16'h0021, 32'hA5000021);
    run_contention(2, 16'h0042, 32'hCAFEF00F, 16'h0022, 32'hA5000022);

    // Second pulse while the first is still pending is dropped
    applyStimulus(1'b1, 1'b0, 4'd1, 16'h0050, 32'h11111111);
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0023;
    tick();
    checkOutput("ovf_core_gnt", {63'd0, core_gnt}, 64'd1);
    applyStimulus(1'b1, 1'b0, 4'd1, 16'h0051, 32'h22222222);
    core_req = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 32'h0);
    checkOutput("ovf_flag",   {63'd0, spi_overflow}, 64'd1);
    checkOutput("ovf_rvalid", {63'd0, core_rvalid}, 64'd1);
    checkOutput("ovf_rdata",  {32'd0, core_rdata}, 64'hA5000023);
    checkOutput("ovf_wait_en",{63'd0, mem_en}, 64'd0);
    tick();
    checkOutput("ovf_first_en",    {63'd0, mem_en}, 64'd1);
    checkOutput("ovf_first_addr",  {48'd0, mem_addr}, 64'h0050);
    checkOutput("ovf_first_wdata", {32'd0, mem_wdata}, 64'h11111111);
    tick();
    checkOutput("ovf_no_second1", {63'd0, mem_en}, 64'd0);
    tick();
    checkOutput("ovf_no_second2", {63'd0, mem_en}, 64'd0);

    // Reset while a core read waits for data
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0024;
    tick();
    checkOutput("rrst_gnt", {63'd0, core_gnt}, 64'd1);
    rst = 1'b1;
    core_req = 1'b0;
    tick();
    checkOutput("rrst_rvalid",   {63'd0, core_rvalid}, 64'd0);
    checkOutput("rrst_mem_en",   {63'd0, mem_en}, 64'd0);
    checkOutput("rrst_mem_addr", {48'd0, mem_addr}, 64'd0);
    checkOutput("rrst_gnt_low",  {63'd0, core_gnt}, 64'd0);
    checkOutput("rrst_ovf",      {63'd0, spi_overflow}, 64'd0);
    checkOutput("rrst_spi_data", {32'd0, spi_read_data}, 64'd0);
    checkOutput("rrst_core_data",{32'd0, core_rdata}, 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("rrst_rvalid_after", {63'd0, core_rvalid}, 64'd0);

    // Simultaneous write and read pulses: write wins, overflow flagged
    applyStimulus(1'b1, 1'b1, 4'd1, 16'h0060, 32'h33333333);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 32'h0);
    checkOutput("both_ovf", {63'd0, spi_overflow}, 64'd1);
    tick();
    checkOutput("both_en",    {63'd0, mem_en}, 64'd1);
    checkOutput("both_we",    {63'd0, mem_we}, 64'd1);
    checkOutput("both_addr",  {48'd0, mem_addr}, 64'h0060);
    checkOutput("both_wdata", {32'd0, mem_wdata}, 64'h33333333);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 32, SHALL set the width of memory words and SPI data.
REQ-002 Parameter ADDRESS_BIT_WIDTH, default 16, SHALL set the width of memory addresses.
REQ-003 Parameter CODE_BIT_WIDTH, default 4, SHALL set the width of the SPI instruction code.
REQ-004 Parameter MEM_CODE, default 1, SHALL give the SPI code value that targets this memory.
REQ-005 clk  input  1  SHALL be the single clock; all state SHALL update on posedge clk.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 spi_write_new  input  1  SHALL be a one-cycle pulse meaning an SPI write word is ready.
REQ-008 spi_read_sync  input  1  SHALL be a one-cycle pulse meaning SPI needs a read word.
REQ-009 spi_code  input  CODE_BIT_WIDTH  SHALL be the SPI instruction code.
REQ-010 spi_address  input  ADDRESS_BIT_WIDTH  SHALL be the SPI target address.
REQ-011 spi_write_data  input  DATA_BIT_WIDTH  SHALL be the SPI write word.
REQ-012 spi_read_data  output  DATA_BIT_WIDTH  SHALL be the registered read result returned to the SPI MISO path.
REQ-013 spi_overflow  output  1  SHALL be a sticky flag marking a dropped SPI request.
REQ-014 core_req, core_we  input  1 each  SHALL be the core request and its write-enable.
REQ-015 core_addr  input  ADDRESS_BIT_WIDTH; core_wdata  input  DATA_BIT_WIDTH  SHALL be the core request fields.
REQ-016 core_gnt  output  1  SHALL be a one-cycle grant pulse.
REQ-017 core_rvalid  output  1; core_rdata  output  DATA_BIT_WIDTH  SHALL return core read data.
REQ-018 mem_en, mem_we  output  1 each; mem_addr  output  ADDRESS_BIT_WIDTH; mem_wdata  output  DATA_BIT_WIDTH  SHALL form a registered single-port memory command.
REQ-019 mem_rdata  input  DATA_BIT_WIDTH  SHALL be valid at the first posedge after a read command (1-cycle latency).

Function
REQ-020 At a posedge where spi_write_new or spi_read_sync is high, spi_code == MEM_CODE and no SPI request is pending, the block SHALL capture the request (type, address, data) into a one-entry pending buffer.
REQ-021 At a posedge where either pulse is high and spi_code != MEM_CODE, the block SHALL ignore the request with no state change.
REQ-022 At a posedge where both pulses are high, the block SHALL capture the write and set spi_overflow.
REQ-023 At a posedge where a MEM_CODE pulse arrives while an SPI request is pending, the block SHALL drop the new request, keep the old one and set spi_overflow.
REQ-024 The FSM SHALL have exactly two states, IDLE and RD_WAIT.
REQ-025 In IDLE, at each posedge, the arbiter SHALL pick at most one requester (pending SPI, or core_req high with core_gnt low) and drive mem_en=1 with that requester's mem_we, mem_addr and mem_wdata for the following cycle; if no requester is picked, mem_en SHALL be 0.
REQ-026 A core pick SHALL pulse core_gnt in the same cycle as its mem_en; core_req SHALL be ignored while core_gnt is high.
REQ-027 Picking the SPI request SHALL clear pending at that edge, so a new SPI pulse can be captured at that same edge.
REQ-028 A picked write SHALL leave the FSM in IDLE, so back-to-back commands are allowed.
REQ-029 A picked read SHALL move the FSM to RD_WAIT.
REQ-030 In RD_WAIT, at the next posedge, the block SHALL capture mem_rdata into spi_read_data (SPI read) or into core_rdata with a one-cycle core_rvalid pulse (core read), issue nothing and return to IDLE.
REQ-031 SPI read latency SHALL be 3 posedges from pulse to spi_read_data update when uncontended.
REQ-032 Core read latency SHALL be 1 cycle from core_gnt to core_rvalid.
REQ-033 spi_read_data SHALL hold its value until the next SPI read completes.
REQ-034 No address arithmetic SHALL be performed; addresses SHALL pass through unchanged.

Reset
REQ-035 When rst is high at a posedge, the FSM SHALL go to IDLE, pending SHALL clear, and spi_read_data, core_rdata, spi_overflow, core_gnt, core_rvalid and all mem_* outputs SHALL become 0.
REQ-036 A read in flight when rst is asserted SHALL be discarded without a core_rvalid pulse.

Configuration
REQ-037 With macro SPI_MEM_ARBITER_FAIR_EN defined, when SPI and core contend the block SHALL grant the requester not granted at the previous contention (first contention after reset: SPI); a last-winner register SHALL reset to core.
REQ-038 Without SPI_MEM_ARBITER_FAIR_EN, a pending SPI request SHALL always win contention.

Verification
REQ-039 SPI write: code=1, addr=0x0010, data=0xDEADBEEF -> one mem_en/mem_we cycle with those values; core_gnt stays 0.
REQ-040 SPI read: code=1, addr=0x0010, memory returns 0xDEADBEEF -> spi_read_data=0xDEADBEEF 3 posedges after the pulse.
REQ-041 SPI pulse with code=0 -> no mem_en; spi_overflow stays 0.
REQ-042 Core read of 0x0020 and SPI write held pending in the same cycle, macro undefined -> SPI write issued first, then core gnt, then core_rvalid; with macro defined -> order alternates over three contentions.
REQ-043 Second SPI pulse while pending -> spi_overflow=1, only the first request reaches memory.
REQ-044 rst asserted during RD_WAIT -> no core_rvalid pulse, all outputs 0 on the next cycle.
